// File: rtl/qdrc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qdrc_arb_pkg
// Description : Shared types and constants for the two-port QDR controller
//               arbiter: requester id, read-tag record, default read latency.
// Revision    : 1.0  initial release
// ============================================================================
package qdrc_arb_pkg;

    // Fixed controller read latency, strobe to usr_rd_dvld; the controller
    // top uses the same constant so both sides stay matched.
    localparam int c_default_rd_latency = 10;

    // Requester identifier (two ports).
    typedef logic [0:0] port_id_t;

    // One slot of the outstanding-read tracker.
    typedef struct packed {
        logic     valid;
        port_id_t id;
    } tag_t;

    localparam tag_t c_tag_empty = '{valid: 1'b0, id: 1'b0};

endpackage : qdrc_arb_pkg
`default_nettype wire

// File: rtl/qdrc_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : qdrc_arb_tag_pipe
// Description : DEPTH-stage shift register of read tags. A tag pushed in the
//               cycle a read strobe is presented reaches the tail exactly
//               DEPTH cycles later, in line with the returned read data.
// Revision    : 1.0  initial release
// ============================================================================
module qdrc_arb_tag_pipe
    import qdrc_arb_pkg::*;
#(
    parameter int DEPTH = c_default_rd_latency
) (
    input  logic clk,
    input  logic reset,
    input  tag_t push_i,
    output tag_t tail_o
);

    tag_t pipe_q [DEPTH];

    // Shift one stage per cycle; reset drops every outstanding tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= c_tag_empty;
            end
        end else begin
            pipe_q[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail_o = pipe_q[DEPTH-1];

endmodule : qdrc_arb_tag_pipe
`default_nettype wire

// File: rtl/qdrc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qdrc_arbiter
// Description : Round-robin arbiter sharing one QDR controller user interface
//               between two requesters. Grants are combinational acks, the
//               granted operation is registered onto the controller bus for
//               one cycle, and read data is steered back by a tag pipe that
//               matches the controller's fixed read latency.
// Revision    : 1.0  initial release
// ============================================================================
module qdrc_arbiter
    import qdrc_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 21,
    parameter int RD_LATENCY = c_default_rd_latency
) (
    input  logic                    clk,
    input  logic                    reset,
    // Port 0
    input  logic                    p0_rd_strb,
    input  logic                    p0_wr_strb,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [2*DATA_WIDTH-1:0] p0_wr_data,
    output logic                    p0_ack,
    output logic [2*DATA_WIDTH-1:0] p0_rd_data,
    output logic                    p0_rd_dvld,
    // Port 1
    input  logic                    p1_rd_strb,
    input  logic                    p1_wr_strb,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [2*DATA_WIDTH-1:0] p1_wr_data,
    output logic                    p1_ack,
    output logic [2*DATA_WIDTH-1:0] p1_rd_data,
    output logic                    p1_rd_dvld,
    // Controller side
    input  logic                    phy_rdy,
    output logic                    qdr_rd_strb,
    output logic                    qdr_wr_strb,
    output logic [ADDR_WIDTH-1:0]   qdr_addr,
    output logic [2*DATA_WIDTH-1:0] qdr_wr_data,
    input  logic [2*DATA_WIDTH-1:0] qdr_rd_data,
    input  logic                    qdr_rd_dvld,
    // Sticky diagnostics
    output logic                    proto_err,
    output logic                    tag_err
);

    localparam int c_udw = 2 * DATA_WIDTH;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    port_id_t              last_grant_q;
    port_id_t              issue_id_q;
    logic                  qdr_rd_strb_q;
    logic                  qdr_wr_strb_q;
    logic [ADDR_WIDTH-1:0] qdr_addr_q;
    logic [c_udw-1:0]      qdr_wr_data_q;
    logic [c_udw-1:0]      p0_rd_data_q;
    logic [c_udw-1:0]      p1_rd_data_q;
    logic                  p0_rd_dvld_q;
    logic                  p1_rd_dvld_q;
    logic                  proto_err_q;
    logic                  proto_err_d;
    logic                  tag_err_q;
    logic                  tag_err_d;

    // ------------------------------------------------------------------
    // Combinational grant path
    // ------------------------------------------------------------------
    logic                  w_req0;
    logic                  w_req1;
    logic                  w_gnt_vld;
    port_id_t              w_gnt_id;
    logic                  w_gnt_rd;
    logic                  w_gnt_wr;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic [c_udw-1:0]      w_gnt_wdata;
    tag_t                  w_push;
    tag_t                  w_tail;

    assign w_req0 = p0_rd_strb | p0_wr_strb;
    assign w_req1 = p1_rd_strb | p1_wr_strb;

    // Round-robin pick: a lone requester wins, contention goes to the port
    // that did not win last; nothing is granted while the PHY is not ready.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (phy_rdy && !reset) begin
            if (w_req0 && w_req1) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~last_grant_q;
            end else if (w_req0) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end else if (w_req1) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
        end
    end

    // Select the winning port's operation; a read takes priority over a
    // write asserted on the same port, and that write is dropped.
    always_comb begin
        if (w_gnt_id == 1'b0) begin
            w_gnt_rd    = p0_rd_strb;
            w_gnt_wr    = p0_wr_strb & ~p0_rd_strb;
            w_gnt_addr  = p0_addr;
            w_gnt_wdata = p0_wr_data;
        end else begin
            w_gnt_rd    = p1_rd_strb;
            w_gnt_wr    = p1_wr_strb & ~p1_rd_strb;
            w_gnt_addr  = p1_addr;
            w_gnt_wdata = p1_wr_data;
        end
    end

    assign p0_ack = w_gnt_vld & (w_gnt_id == 1'b0);
    assign p1_ack = w_gnt_vld & (w_gnt_id == 1'b1);

    // Register the granted operation onto the controller bus for one cycle;
    // address and write data hold between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            issue_id_q    <= 1'b0;
            qdr_rd_strb_q <= 1'b0;
            qdr_wr_strb_q <= 1'b0;
            qdr_addr_q    <= '0;
            qdr_wr_data_q <= '0;
        end else begin
            qdr_rd_strb_q <= w_gnt_vld & w_gnt_rd;
            qdr_wr_strb_q <= w_gnt_vld & w_gnt_wr;
            if (w_gnt_vld) begin
                last_grant_q <= w_gnt_id;
                issue_id_q   <= w_gnt_id;
                qdr_addr_q   <= w_gnt_addr;
            end
            if (w_gnt_vld && w_gnt_wr) begin
                qdr_wr_data_q <= w_gnt_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read tracking
    // ------------------------------------------------------------------
    // A tag enters the pipe in the same cycle the read strobe is driven.
    always_comb begin
        w_push.valid = qdr_rd_strb_q;
        w_push.id    = issue_id_q;
    end

    qdrc_arb_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .push_i (w_push),
        .tail_o (w_tail)
    );

    // Sticky error next-state: dual strobes on a port, or return/tag skew.
    always_comb begin
        proto_err_d = proto_err_q | (p0_rd_strb & p0_wr_strb)
                                  | (p1_rd_strb & p1_wr_strb);
        tag_err_d   = tag_err_q | (qdr_rd_dvld ^ w_tail.valid);
    end

    // Steer returned data to the port named by the tail tag; untagged or
    // missing returns produce no dvld.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_rd_data_q <= '0;
            p1_rd_data_q <= '0;
            p0_rd_dvld_q <= 1'b0;
            p1_rd_dvld_q <= 1'b0;
            proto_err_q  <= 1'b0;
            tag_err_q    <= 1'b0;
        end else begin
            p0_rd_dvld_q <= 1'b0;
            p1_rd_dvld_q <= 1'b0;
            if (qdr_rd_dvld && w_tail.valid) begin
                if (w_tail.id == 1'b0) begin
                    p0_rd_data_q <= qdr_rd_data;
                    p0_rd_dvld_q <= 1'b1;
                end else begin
                    p1_rd_data_q <= qdr_rd_data;
                    p1_rd_dvld_q <= 1'b1;
                end
            end
            proto_err_q <= proto_err_d;
            tag_err_q   <= tag_err_d;
        end
    end

    assign qdr_rd_strb = qdr_rd_strb_q;
    assign qdr_wr_strb = qdr_wr_strb_q;
    assign qdr_addr    = qdr_addr_q;
    assign qdr_wr_data = qdr_wr_data_q;
    assign p0_rd_data  = p0_rd_data_q;
    assign p1_rd_data  = p1_rd_data_q;
    assign p0_rd_dvld  = p0_rd_dvld_q;
    assign p1_rd_dvld  = p1_rd_dvld_q;
    assign proto_err   = proto_err_q;
    assign tag_err     = tag_err_q;

endmodule : qdrc_arbiter
`default_nettype wire

// File: tb/tb_qdrc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_qdrc_arbiter
// Description : Directed, scoreboard-based bench for qdrc_arbiter with a
//               fixed-latency QDR controller model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_qdrc_arbiter;

    localparam int DW  = 36;
    localparam int AW  = 21;
    localparam int LAT = 10;
    localparam int UDW = 2 * DW;

    typedef logic [UDW-1:0] v_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           p0_rd_strb, p0_wr_strb, p1_rd_strb, p1_wr_strb;
    logic [AW-1:0]  p0_addr, p1_addr;
    logic [UDW-1:0] p0_wr_data, p1_wr_data;
    logic           p0_ack, p1_ack, p0_rd_dvld, p1_rd_dvld;
    logic [UDW-1:0] p0_rd_data, p1_rd_data;
    logic           phy_rdy;
    logic           qdr_rd_strb, qdr_wr_strb;
    logic [AW-1:0]  qdr_addr;
    logic [UDW-1:0] qdr_wr_data;
    logic [UDW-1:0] qdr_rd_data;
    logic           qdr_rd_dvld;
    logic           proto_err, tag_err;

    qdrc_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .p0_rd_strb  (p0_rd_strb),
        .p0_wr_strb  (p0_wr_strb),
        .p0_addr     (p0_addr),
        .p0_wr_data  (p0_wr_data),
        .p0_ack      (p0_ack),
        .p0_rd_data  (p0_rd_data),
        .p0_rd_dvld  (p0_rd_dvld),
        .p1_rd_strb  (p1_rd_strb),
        .p1_wr_strb  (p1_wr_strb),
        .p1_addr     (p1_addr),
        .p1_wr_data  (p1_wr_data),
        .p1_ack      (p1_ack),
        .p1_rd_data  (p1_rd_data),
        .p1_rd_dvld  (p1_rd_dvld),
        .phy_rdy     (phy_rdy),
        .qdr_rd_strb (qdr_rd_strb),
        .qdr_wr_strb (qdr_wr_strb),
        .qdr_addr    (qdr_addr),
        .qdr_wr_data (qdr_wr_data),
        .qdr_rd_data (qdr_rd_data),
        .qdr_rd_dvld (qdr_rd_dvld),
        .proto_err   (proto_err),
        .tag_err     (tag_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entries: expected controller issue and expected returns.
    typedef struct {
        int            cyc;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        v_t            data;
    } iss_t;
    typedef struct {
        int cyc;
        v_t data;
    } ret_t;

    iss_t iss_q [$];
    ret_t ret0_q [$];
    ret_t ret1_q [$];
    iss_t mon_i;
    ret_t mon_r;

    task automatic chk(input string name, input v_t act, input v_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read data the controller model returns for a given address.
    function automatic v_t mkdata(input logic [AW-1:0] a);
        return {a, 30'h2BADF00D, ~a};
    endfunction

    // Controller model: fixed-latency read return plus optional spurious dvld.
    logic          inject;
    logic [LAT-1:0] m_vld;
    logic [AW-1:0] m_addr [LAT];

    initial begin
        qdr_rd_dvld = 1'b0;
        qdr_rd_data = '0;
        m_vld       = '0;
        for (int i = 0; i < LAT; i++) m_addr[i] = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                m_vld       = '0;
                qdr_rd_dvld = 1'b0;
            end else begin
                qdr_rd_dvld = m_vld[LAT-1] | inject;
                if (m_vld[LAT-1])
                    qdr_rd_data = mkdata(m_addr[LAT-1]);
                else if (inject)
                    qdr_rd_data = 72'h0BAD_0BAD;
                for (int i = LAT - 1; i > 0; i--) begin
                    m_vld[i]  = m_vld[i-1];
                    m_addr[i] = m_addr[i-1];
                end
                m_vld[0]  = qdr_rd_strb;
                m_addr[0] = qdr_addr;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an issue or a return.
    initial begin
        forever begin
            @(negedge clk);
            if (qdr_rd_strb || qdr_wr_strb) begin
                if (iss_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL issue_unexpected: got rd=%0b wr=%0b addr=%0h expected no issue (cycle %0d)",
                             qdr_rd_strb, qdr_wr_strb, qdr_addr, cyc);
                end else begin
                    mon_i = iss_q.pop_front();
                    chk("issue_cycle", v_t'(cyc), v_t'(mon_i.cyc));
                    chk("issue_rd", v_t'(qdr_rd_strb), v_t'(mon_i.rd));
                    chk("issue_wr", v_t'(qdr_wr_strb), v_t'(mon_i.wr));
                    chk("issue_addr", v_t'(qdr_addr), v_t'(mon_i.addr));
                    if (mon_i.wr) chk("issue_wdata", qdr_wr_data, mon_i.data);
                end
            end
            if (p0_rd_dvld) begin
                if (ret0_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL p0_dvld_unexpected: got dvld=1 data=%0h expected no dvld (cycle %0d)", p0_rd_data, cyc);
                end else begin
                    mon_r = ret0_q.pop_front();
                    chk("p0_ret_cycle", v_t'(cyc), v_t'(mon_r.cyc));
                    chk("p0_ret_data", p0_rd_data, mon_r.data);
                end
            end
            if (p1_rd_dvld) begin
                if (ret1_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL p1_dvld_unexpected: got dvld=1 data=%0h expected no dvld (cycle %0d)", p1_rd_data, cyc);
                end else begin
                    mon_r = ret1_q.pop_front();
                    chk("p1_ret_cycle", v_t'(cyc), v_t'(mon_r.cyc));
                    chk("p1_ret_data", p1_rd_data, mon_r.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_p0_ack"}, v_t'(p0_ack), '0);
        chk({tag, "_p1_ack"}, v_t'(p1_ack), '0);
        chk({tag, "_qdr_rd_strb"}, v_t'(qdr_rd_strb), '0);
        chk({tag, "_qdr_wr_strb"}, v_t'(qdr_wr_strb), '0);
        chk({tag, "_qdr_addr"}, v_t'(qdr_addr), '0);
        chk({tag, "_qdr_wr_data"}, qdr_wr_data, '0);
        chk({tag, "_p0_rd_data"}, p0_rd_data, '0);
        chk({tag, "_p1_rd_data"}, p1_rd_data, '0);
        chk({tag, "_p0_rd_dvld"}, v_t'(p0_rd_dvld), '0);
        chk({tag, "_p1_rd_dvld"}, v_t'(p1_rd_dvld), '0);
        chk({tag, "_proto_err"}, v_t'(proto_err), '0);
        chk({tag, "_tag_err"}, v_t'(tag_err), '0);
    endtask

    task automatic push_iss(input logic rd, input logic wr, input logic [AW-1:0] a, input v_t d);
        iss_t e;
        e.cyc = cyc + 1; e.rd = rd; e.wr = wr; e.addr = a; e.data = d;
        iss_q.push_back(e);
    endtask

    task automatic push_ret(input int port, input logic [AW-1:0] a);
        ret_t e;
        e.cyc  = cyc + LAT + 2;
        e.data = mkdata(a);
        if (port == 0) ret0_q.push_back(e);
        else           ret1_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; phy_rdy = 1'b0; inject = 1'b0;
        p0_rd_strb = 1'b0; p0_wr_strb = 1'b0; p0_addr = '0; p0_wr_data = '0;
        p1_rd_strb = 1'b0; p1_wr_strb = 1'b0; p1_addr = '0; p1_wr_data = '0;
        repeat (3) tick();
        sample();
        chk_reset_state("rst");

        // Gating by phy_rdy, then the first grant.
        tick();
        reset = 1'b0; p0_rd_strb = 1'b1; p0_addr = 21'h10;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("gated_p0_ack", v_t'(p0_ack), '0);
            chk("gated_qdr_rd_strb", v_t'(qdr_rd_strb), '0);
            tick();
        end
        phy_rdy = 1'b1;
        sample();
        chk("first_p0_ack", v_t'(p0_ack), 72'd1);
        push_iss(1'b1, 1'b0, 21'h10, '0);
        push_ret(0, 21'h10);
        tick();
        p0_rd_strb = 1'b0;
        repeat (14) tick();

        // Fresh reset so contention starts with port 0.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Both ports holding writes: strict alternation 0,1,0,1,0,1.
        p0_wr_strb = 1'b1; p0_addr = 21'h100;
        p1_wr_strb = 1'b1; p1_addr = 21'h200;
        for (int i = 0; i < 6; i++) begin
            p0_wr_data = 72'h1000 + 72'(i);
            p1_wr_data = 72'h2000 + 72'(i);
            sample();
            chk("rr_p0_ack", v_t'(p0_ack), v_t'(((i % 2) == 0) ? 1 : 0));
            chk("rr_p1_ack", v_t'(p1_ack), v_t'(((i % 2) == 1) ? 1 : 0));
            if ((i % 2) == 0) push_iss(1'b0, 1'b1, 21'h100, 72'h1000 + 72'(i));
            else              push_iss(1'b0, 1'b1, 21'h200, 72'h2000 + 72'(i));
            tick();
        end
        p0_wr_strb = 1'b0; p1_wr_strb = 1'b0;
        tick();

        // Back-to-back reads from alternating ports.
        p0_rd_strb = 1'b1; p0_addr = 21'h10;
        sample();
        chk("b2b_p0_ack", v_t'(p0_ack), 72'd1);
        chk("b2b_p1_ack0", v_t'(p1_ack), '0);
        push_iss(1'b1, 1'b0, 21'h10, '0);
        push_ret(0, 21'h10);
        tick();
        p0_rd_strb = 1'b0; p1_rd_strb = 1'b1; p1_addr = 21'h20;
        sample();
        chk("b2b_p1_ack", v_t'(p1_ack), 72'd1);
        chk("b2b_p0_ack0", v_t'(p0_ack), '0);
        push_iss(1'b1, 1'b0, 21'h20, '0);
        push_ret(1, 21'h20);
        tick();
        p1_rd_strb = 1'b0;
        repeat (14) tick();

        // Simultaneous rd+wr on port 1: read wins, write dropped, proto_err.
        p1_rd_strb = 1'b1; p1_wr_strb = 1'b1; p1_addr = 21'h30; p1_wr_data = 72'hDEAD;
        sample();
        chk("dual_p1_ack", v_t'(p1_ack), 72'd1);
        chk("dual_proto_err_pre", v_t'(proto_err), '0);
        push_iss(1'b1, 1'b0, 21'h30, '0);
        push_ret(1, 21'h30);
        tick();
        p1_rd_strb = 1'b0; p1_wr_strb = 1'b0;
        sample();
        chk("dual_proto_err_set", v_t'(proto_err), 72'd1);
        repeat (14) tick();
        sample();
        chk("dual_proto_err_sticky", v_t'(proto_err), 72'd1);

        // Spurious return with nothing outstanding.
        chk("inj_tag_err_pre", v_t'(tag_err), '0);
        tick();
        inject = 1'b1;
        sample();
        chk("inj_tag_err_same_cycle", v_t'(tag_err), '0);
        tick();
        inject = 1'b0;
        sample();
        chk("inj_tag_err_set", v_t'(tag_err), 72'd1);
        chk("inj_p0_dvld", v_t'(p0_rd_dvld), '0);
        chk("inj_p1_dvld", v_t'(p1_rd_dvld), '0);
        repeat (3) tick();
        sample();
        chk("inj_tag_err_sticky", v_t'(tag_err), 72'd1);

        // Reset while a read is in flight: nothing comes back.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        p0_rd_strb = 1'b1; p0_addr = 21'h44;
        sample();
        chk("midrst_p0_ack", v_t'(p0_ack), 72'd1);
        push_iss(1'b1, 1'b0, 21'h44, '0);
        tick();
        p0_rd_strb = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        sample();
        chk_reset_state("midrst");
        repeat (16) tick();
        sample();
        chk("midrst_tag_err_end", v_t'(tag_err), '0);
        chk("midrst_p0_dvld_end", v_t'(p0_rd_dvld), '0);

        // Everything expected must have been seen.
        chk("iss_q_drained", v_t'(iss_q.size()), '0);
        chk("ret0_q_drained", v_t'(ret0_q.size()), '0);
        chk("ret1_q_drained", v_t'(ret1_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_qdrc_arbiter
`default_nettype wire

// File: doc/qdrc_arbiter.md
Name: qdrc_arbiter

Overview:
- Two-port round-robin arbiter that shares the single QDR controller user interface (rd/wr strobe, shared address, write data, read data and dvld) between two requesters.
- Sits between user logic and the QDR controller top, in the clk0 domain.
- Tracks outstanding reads with a tag pipeline matched to the controller's fixed read latency, and steers returned read data to the issuing port.

Parameters:
- DATA_WIDTH, 36, QDR data width; the user data bus is 2*DATA_WIDTH.
- ADDR_WIDTH, 21, QDR burst address width.
- RD_LATENCY, 10, cycles from qdr_rd_strb to qdr_rd_dvld. Must equal the controller's fixed latency; minimum 2.

Ports:
- clk  in  1  controller clock (clk0 domain).
- reset  in  1  synchronous, active-high reset.
- pN_rd_strb  in  1  port N (N=0,1) read request, held until ack.
- pN_wr_strb  in  1  port N write request, held until ack.
- pN_addr  in  ADDR_WIDTH  port N address, stable while strobe is high.
- pN_wr_data  in  2*DATA_WIDTH  port N write data, stable while wr_strb is high.
- pN_ack  out  1  combinational grant; the request is consumed in this cycle.
- pN_rd_data  out  2*DATA_WIDTH  port N read data, registered.
- pN_rd_dvld  out  1  port N read data valid, one-cycle pulse.
- phy_rdy  in  1  controller calibrated and ready.
- qdr_rd_strb  out  1  to controller usr_rd_strb, registered.
- qdr_wr_strb  out  1  to controller usr_wr_strb, registered.
- qdr_addr  out  ADDR_WIDTH  to controller usr_addr, registered.
- qdr_wr_data  out  2*DATA_WIDTH  to controller usr_wr_data, registered.
- qdr_rd_data  in  2*DATA_WIDTH  from controller usr_rd_data.
- qdr_rd_dvld  in  1  from controller usr_rd_dvld.
- proto_err  out  1  sticky: a port asserted rd and wr in the same cycle.
- tag_err  out  1  sticky: qdr_rd_dvld disagrees with the tail of the tag pipe.

Behaviour:
- Reset values: all outputs 0, tag pipe cleared, last_grant=1 (so port 0 wins the first contention).
- Request definition: req_N = pN_rd_strb | pN_wr_strb.
- Gating: no ack is issued while phy_rdy=0. Requests stay pending and qdr strobes stay 0.
- Grant rules (phy_rdy=1):
  - Exactly one requester: that port is granted.
  - Both requesting: grant the port != last_grant.
  - last_grant updates on every grant.
  - At most one operation per cycle.
- Ack: pN_ack is combinational in the grant cycle. The requester may drop or change its strobe on the next edge.
- Issue: on the edge after a grant, the qdr_* outputs register the granted port's op, address and data for exactly one cycle. Otherwise strobes are 0; addr and data hold their previous values.
- Simultaneous rd+wr on one port:
  - The read is issued and acked.
  - The write is discarded.
  - proto_err is set and stays set until reset.
- Tag pipe: RD_LATENCY-deep shift register of {valid, port_id}.
  - Entry: {1, granted id} in the same cycle qdr_rd_strb is driven high; otherwise {0, x}.
  - The tail aligns with qdr_rd_dvld.
- Return path, on qdr_rd_dvld=1 with tail valid:
  - Next edge: pId_rd_data <= qdr_rd_data and pId_rd_dvld <= 1.
  - The other port's dvld stays 0.
- Return mismatches:
  - qdr_rd_dvld=1 with tail invalid: data dropped, tag_err set.
  - Tail valid with qdr_rd_dvld=0: tag_err set, no dvld issued.
- Read latency: ack cycle to pN_rd_dvld is RD_LATENCY+2 cycles (12 at default).
- Back-to-back: full throughput of one op per cycle. Reads from alternating ports return in issue order with no bubbles.
- phy_rdy falling mid-operation: new grants stop immediately; in-flight tags still drain and return data.
- Reset mid-operation: tag pipe and outputs clear; in-flight reads return no dvld.

Decomposition:
- Package qdrc_arb_pkg holds:
  - port id typedef (1 bit);
  - tag struct {valid, id};
  - the default RD_LATENCY constant, shared with the controller top.
- Sub-module qdrc_arb_tag_pipe: parameterised shift register of tags with push and tail outputs.

Test Plan:
- reset, phy_rdy=0, p0 read addr 0x10 held 5 cycles -> p0_ack=0, qdr_rd_strb=0. Then phy_rdy=1 -> p0_ack=1 that cycle; next cycle qdr_rd_strb=1, qdr_addr=0x10.
- Both ports hold continuous writes (p0 addr 0x100, p1 addr 0x200) for 6 cycles -> grant order 0,1,0,1,0,1; qdr_wr_strb=1 every issue cycle with the matching addr and data.
- p0 read 0x10 then p1 read 0x20 on consecutive cycles; controller model returns dvld+data RD_LATENCY after each strb -> p0_rd_dvld at ack+12 with the 0x10 data, p1_rd_dvld at ack+12 of its own grant (one cycle later), with no cross-steering.
- p1 asserts rd and wr together at addr 0x30 -> p1_ack=1, only qdr_rd_strb issues, proto_err=1 and stays set.
- Model injects qdr_rd_dvld=1 with no read outstanding -> tag_err=1, p0_rd_dvld=p1_rd_dvld=0.
- p0 read issued, reset pulsed 4 cycles later, model returns no dvld -> no dvld on any port, tag_err=0, all outputs at reset values.
